// File: rtl/macplus_kbd_pkg.sv
// Shared constants for the Mac Plus keyboard controller.
//   - Mac keyboard command bytes understood by the controller
//   - Response bytes for the null, ACK and NAK replies
//   - Controller FSM state type
package macplus_kbd_pkg;

   localparam logic [7:0] CMD_INQUIRY = 8'h10;
   localparam logic [7:0] CMD_INSTANT = 8'h14;
   localparam logic [7:0] CMD_MODEL   = 8'h16;
   localparam logic [7:0] CMD_TEST    = 8'h36;

   localparam logic [7:0] RSP_NULL = 8'h7B;
   localparam logic [7:0] RSP_ACK  = 8'h7D;
   localparam logic [7:0] RSP_NAK  = 8'h77;

   typedef enum logic [1:0] {
      StIdle,
      StDecode,
      StWaitInq,
      StRespond
   } kbd_state_e;

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous byte FIFO for buffered keyboard events.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   push, push_data write request and byte (ignored while full)
//   pop             drop the head entry (ignored while empty)
//   flush           empty the FIFO; takes precedence over push and pop
//   head            current head entry (valid while not empty)
//   full, empty     occupancy flags
//   level           current occupancy, 0..DEPTH
// Pointers carry one extra wrap bit: equal when empty, MSB differs when full.
module kbd_event_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [7:0]    head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign head    = mem[rd_ptr_q[AW-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/macplus_kbd_ctrl.sv
// Mac Plus keyboard command sequencer.
// Buffers key events from the HID toggle-strobe interface in a FIFO and answers
// the Mac keyboard commands Inquiry, Instant, Model and Test.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   kbd_strobe, kbd_data    toggle strobe + event byte {release, keycode[6:0]}
//   cmd_strobe, cmd_data    one-cycle command pulse + command byte
//   rsp_strobe, rsp_data    one-cycle response pulse + response byte
//   busy                    command accepted, response not yet strobed
//   overflow                sticky: an event was dropped on a full FIFO
//   fifo_level              current FIFO occupancy
// Build option: MACKBD_DEDUP_EN drops an event equal to the last pushed byte.
module macplus_kbd_ctrl
   import macplus_kbd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned INQ_TICKS  = 8000000,
   parameter logic [7:0]  MODEL_ID   = 8'h0B,
   localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          kbd_strobe,
   input  logic [7:0]    kbd_data,
   input  logic          cmd_strobe,
   input  logic [7:0]    cmd_data,
   output logic          rsp_strobe,
   output logic [7:0]    rsp_data,
   output logic          busy,
   output logic          overflow,
   output logic [LW-1:0] fifo_level
);

   localparam int unsigned CW = (INQ_TICKS > 1) ? $clog2(INQ_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(INQ_TICKS - 1);

   kbd_state_e    state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    rsp_q, rsp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          strobe_q;
   logic          overflow_q;

   logic          kbd_event, dup, accept_evt, push, pop, flush;
   logic          full, empty;
   logic [7:0]    head;

   // Any edge on the toggle strobe is a new event.
   assign kbd_event = kbd_strobe ^ strobe_q;

`ifdef MACKBD_DEDUP_EN
   logic [7:0] last_q;

   assign dup = (kbd_data == last_q);

   always_ff @(posedge clk) begin
      if (reset || flush) last_q <= 8'hFF;
      else if (push)      last_q <= kbd_data;
   end
`else
   assign dup = 1'b0;
`endif

   // A flush cycle discards any incoming event without flagging overflow.
   assign accept_evt = kbd_event && !dup && !flush;
   assign push       = accept_evt && !full;

   kbd_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (kbd_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      rsp_d   = rsp_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      flush   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_strobe) begin
               cmd_d   = cmd_data;
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = StRespond;
            case (cmd_q)
               CMD_INQUIRY: begin
                  if (!empty) begin
                     pop   = 1'b1;
                     rsp_d = head;
                  end else begin
                     cnt_d   = '0;
                     state_d = StWaitInq;
                  end
               end
               CMD_INSTANT: begin
                  if (!empty) begin
                     pop   = 1'b1;
                     rsp_d = head;
                  end else begin
                     rsp_d = RSP_NULL;
                  end
               end
               CMD_MODEL: begin
                  flush = 1'b1;
                  rsp_d = MODEL_ID;
               end
               CMD_TEST: rsp_d = RSP_ACK;
               default:  rsp_d = RSP_NAK;
            endcase
         end
         StWaitInq: begin
            cnt_d = cnt_q + CW'(1);
            // A buffered event beats a coincident timeout.
            if (!empty) begin
               pop     = 1'b1;
               rsp_d   = head;
               state_d = StRespond;
            end else if (cnt_q == CNT_LAST) begin
               rsp_d   = RSP_NULL;
               state_d = StRespond;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         rsp_q      <= '0;
         cnt_q      <= '0;
         strobe_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         rsp_q    <= rsp_d;
         cnt_q    <= cnt_d;
         strobe_q <= kbd_strobe;
         if (flush)                  overflow_q <= 1'b0;
         else if (accept_evt && full) overflow_q <= 1'b1;
      end
   end

   assign rsp_strobe = (state_q == StRespond);
   assign busy       = (state_q != StIdle);
   assign rsp_data   = rsp_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_macplus_kbd_ctrl.sv
// Self-checking bench for macplus_kbd_ctrl against a queue-based reference model.
module tb_macplus_kbd_ctrl;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TICKS = 1000;
`ifdef MACKBD_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       kbd_strobe, cmd_strobe;
   logic [7:0] kbd_data, cmd_data;
   logic       rsp_strobe, busy, overflow;
   logic [7:0] rsp_data;
   logic [3:0] fifo_level;

   macplus_kbd_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .INQ_TICKS  (TICKS),
      .MODEL_ID   (8'h0B)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .kbd_strobe (kbd_strobe),
      .kbd_data   (kbd_data),
      .cmd_strobe (cmd_strobe),
      .cmd_data   (cmd_data),
      .rsp_strobe (rsp_strobe),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: event queue, sticky overflow, last accepted byte.
   logic [7:0] mq[$];
   bit         m_ovf;
   logic [7:0] m_last;

   function automatic void m_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_last = 8'hFF;
   endfunction

   function automatic void m_push(logic [7:0] b);
      if (DEDUP && b == m_last) return;
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else begin
         mq.push_back(b);
         m_last = b;
      end
   endfunction

   function automatic logic [7:0] m_cmd(logic [7:0] c);
      logic [7:0] r;
      case (c)
         8'h10, 8'h14: r = (mq.size() > 0) ? mq.pop_front() : 8'h7B;
         8'h16: begin
            m_reset();
            r = 8'h0B;
         end
         8'h36:   r = 8'h7D;
         default: r = 8'h77;
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic kbd_event(input logic [7:0] b);
      kbd_data   = b;
      kbd_strobe = ~kbd_strobe;
      step();
      m_push(b);
      chk("evt_level", 32'(fifo_level), 32'(mq.size()));
      chk("evt_ovf", 32'(overflow), 32'(m_ovf));
   endtask

   // Issues a command, optionally toggles an event at cycle ev_at after the
   // command cycle, and checks response byte, latency and busy framing.
   task automatic run_cmd(input logic [7:0] c, input logic [7:0] exp, input int exp_lat,
                          input int ev_at, input logic [7:0] ev_b);
      int lat;
      bit busy_bad;
      busy_bad   = 1'b0;
      cmd_data   = c;
      cmd_strobe = 1'b1;
      step();
      cmd_strobe = 1'b0;
      lat = 1;
      while (rsp_strobe !== 1'b1 && lat < int'(TICKS) + 20) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (lat == ev_at) begin
            kbd_data   = ev_b;
            kbd_strobe = ~kbd_strobe;
         end
         step();
         lat++;
      end
      chk("rsp_lat", 32'(lat), 32'(exp_lat));
      chk("rsp_data", 32'(rsp_data), 32'(exp));
      chk("busy_hold", 32'({busy_bad, busy}), 32'(1));
      step();
      chk("busy_drop", 32'({busy, rsp_strobe}), 32'(0));
   endtask

   initial begin
      int n;
      logic [7:0] c;
      logic [7:0] e;
      reset      = 1'b1;
      kbd_strobe = 1'b0;
      kbd_data   = 8'h00;
      cmd_strobe = 1'b0;
      cmd_data   = 8'h00;
      m_reset();
      repeat (3) step();
      reset = 1'b0;
      step();

      chk("rst_strobe", 32'(rsp_strobe), 32'(0));
      chk("rst_data", 32'(rsp_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      chk("rst_level", 32'(fifo_level), 32'(0));

      // Two events then three Instants.
      kbd_event(8'h12);
      kbd_event(8'h92);
      run_cmd(8'h14, 8'h12, 2, -1, 8'h00); void'(m_cmd(8'h14));
      run_cmd(8'h14, 8'h92, 2, -1, 8'h00); void'(m_cmd(8'h14));
      run_cmd(8'h14, 8'h7B, 2, -1, 8'h00); void'(m_cmd(8'h14));

      // Inquiry on empty FIFO, event after 100 cycles.
      run_cmd(8'h10, 8'h24, 102, 100, 8'h24);
      m_last = (DEDUP && mq.size() < DEPTH) ? 8'h24 : m_last;

      // Inquiry timeout.
      run_cmd(8'h10, 8'h7B, TICKS + 2, -1, 8'h00);
      // Event visible exactly at the timeout cycle wins.
      run_cmd(8'h10, 8'h35, TICKS + 2, TICKS, 8'h35);
      m_last = 8'h35;
      // Event one cycle later loses to the timeout and stays buffered.
      run_cmd(8'h10, 8'h7B, TICKS + 2, TICKS + 1, 8'h46);
      m_push(8'h46);
      chk("late_evt_level", 32'(fifo_level), 32'(mq.size()));
      run_cmd(8'h14, m_cmd(8'h14), 2, -1, 8'h00);

      // Overflow then Model flush.
      for (int i = 0; i <= int'(DEPTH); i++) kbd_event(8'h40 + 8'(i));
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
      run_cmd(8'h16, m_cmd(8'h16), 2, -1, 8'h00);
      chk("model_level", 32'(fifo_level), 32'(0));
      chk("model_ovf", 32'(overflow), 32'(0));

      // Repeated key-down suppression.
      kbd_event(8'h12);
      kbd_event(8'h12);
      kbd_event(8'h92);
      chk("dedup_level", 32'(fifo_level), DEDUP ? 32'(2) : 32'(3));
      while (mq.size() > 0) run_cmd(8'h14, m_cmd(8'h14), 2, -1, 8'h00);

      // Test, unknown, and a second strobe while busy.
      run_cmd(8'h36, m_cmd(8'h36), 2, -1, 8'h00);
      run_cmd(8'h55, m_cmd(8'h55), 2, -1, 8'h00);
      kbd_event(8'h33);
      cmd_data   = 8'h36;
      cmd_strobe = 1'b1;
      step();
      cmd_data = 8'h16;
      step();
      cmd_strobe = 1'b0;
      chk("ign_strobe", 32'(rsp_strobe), 32'(1));
      chk("ign_data", 32'(rsp_data), 32'(8'h7D));
      n = 0;
      repeat (6) begin
         step();
         if (rsp_strobe === 1'b1) n++;
      end
      chk("ign_extra", 32'(n), 32'(0));
      chk("ign_level", 32'(fifo_level), 32'(mq.size()));
      run_cmd(8'h14, m_cmd(8'h14), 2, -1, 8'h00);

      // Reset while an Inquiry waits: no response ever appears.
      cmd_data   = 8'h10;
      cmd_strobe = 1'b1;
      step();
      cmd_strobe = 1'b0;
      repeat (5) step();
      reset      = 1'b1;
      kbd_strobe = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      m_reset();
      n = 0;
      repeat (TICKS + 10) begin
         step();
         if (rsp_strobe === 1'b1) n++;
      end
      chk("rst_mid_strobe", 32'(n), 32'(0));
      chk("rst_mid_busy", 32'(busy), 32'(0));

      // Randomized mix of events and commands.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            kbd_event(8'($urandom_range(0, 255)));
         end else begin
            case ($urandom_range(0, 5))
               0:       c = 8'h10;
               1, 2:    c = 8'h14;
               3:       c = 8'h16;
               4:       c = 8'h36;
               default: c = 8'($urandom_range(0, 255));
            endcase
            n = (c == 8'h10 && mq.size() == 0) ? int'(TICKS) + 2 : 2;
            e = m_cmd(c);
            run_cmd(c, e, n, -1, 8'h00);
            chk("rnd_level", 32'(fifo_level), 32'(mq.size()));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
         end
         repeat ($urandom_range(0, 2)) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
